cmsdk_ahb_to_ahb_apb_async_master_rx: RTL and testbench
=======================================================

// Module: cmsdk_ahb_to_ahb_apb_async_master_rx
// PURPOSE
//  Master-side receive stage of the async AHB-Lite to AHB-Lite/APB4 bridge, in the HCLKM domain.
//  Synchronises the slave-side transmit semaphore (toggle) and the slave lock flag into HCLKM.
//  Registers the slave-to-master request payload on the same edge that the request is presented.
//  Feeds the master-side FSM (m_rx_sema_q, m_lock_q, payload fields) and drives the AHB/APB address/write-data buses.
//  Flags a protocol error if a new slave toggle arrives while a master transfer is still outstanding.
// PARAMETERS
//  SYNC_STAGES  2   flops per synchroniser chain (semaphore and lock); legal range 2..4
//  ADDR_WIDTH   32  HADDR width; legal range 12..32
// PORTS
//  HCLKM            in   1           master clock
//  HRESETMn         in   1           async active-low reset
//  s_tx_sema_q      in   1           slave semaphore toggle (async to HCLKM)
//  s_hmastlock_q    in   1           slave lock flag (async)
//  s_haddr_q        in   ADDR_WIDTH  slave payload: address (stable while toggle pending)
//  s_hwrite_q       in   1           payload: write
//  s_hsize_q        in   3           payload: size
//  s_hprot_q        in   4           payload: prot
//  s_hselapb_q      in   1           payload: APB target select
//  s_hmastlock_pl_q in   1           payload: HMASTLOCK of this transfer
//  s_hwdata_q       in   32          payload: write data
//  m_mask           in   1           from master FSM; 1 = no cycle active, zero the bus outputs
//  m_tx_sema_q      in   1           master return semaphore (from master FSM register)
//  m_rx_sema_q      out  1           synchronised, payload-aligned request semaphore
//  m_lock_q         out  1           synchronised slave lock
//  m_haddr_q        out  ADDR_WIDTH  masked captured address (HADDRM/PADDRM)
//  m_haddr_q_1to0   out  2           unmasked captured address bits [1:0]
//  m_hsize_q        out  3           masked captured size; [1:0] also feeds the strobe logic
//  m_hprot_q        out  4           masked captured prot (HPROTM; PPROTM derived outside)
//  m_hwrite_q       out  1           captured write, unmasked
//  m_hselapb_q      out  1           captured APB select, unmasked
//  m_hmastlock_q    out  1           captured lock, unmasked
//  m_hwdata_q       out  32          masked captured write data
//  m_proto_err      out  1           sticky protocol-error flag
// BEHAVIOUR
//  Reset: every flop clears to 0, so every output is 0.
//   After reset release, a slave toggle left at 1 shows up as a request after SYNC_STAGES+1 edges.
//   The master FSM's in-reset cycle covers the first cycle after release.
//  Semaphore chain
//   - sema_sync[0..SYNC_STAGES-1] samples s_tx_sema_q every edge; sema_s = last stage.
//   - new_tog = sema_s != m_rx_sema_q.
//   - When new_tog: m_rx_sema_q <= sema_s, and on the same edge all payload registers load from s_*.
//   - Otherwise payload registers hold.
//   - Latency: a toggle on s_tx_sema_q reaches m_rx_sema_q after SYNC_STAGES+1 HCLKM edges.
//   - Payload is never sampled before its semaphore has passed the synchroniser, so no payload bit is metastable.
//  Lock chain
//   - SYNC_STAGES flops on s_hmastlock_q; m_lock_q = last stage.
//   - Not aligned to the semaphore; reconvergence is handled by the master FSM's delayed unlock.
//  Masking
//   - m_haddr_q, m_hsize_q, m_hprot_q, m_hwdata_q = captured value & ~m_mask (all bits 0 while masked).
//   - m_haddr_q_1to0, m_hwrite_q, m_hselapb_q, m_hmastlock_q bypass the mask; the FSM needs them while idle for unlock decisions.
//  Protocol check
//   - busy = m_rx_sema_q != m_tx_sema_q.
//   - new_tog & busy sets m_proto_err; it clears only on reset.
//   - The capture still happens: last toggle wins; no stall.
//  Simultaneous events
//   - new_tog in the same cycle the FSM updates m_tx_sema_q to equal the old m_rx_sema_q is legal (back-to-back); no error.
//   - Two toggles inside one synchroniser window collapse (net zero) and are not detected; the slave protocol forbids this.
//  Reset mid-transfer clears captured payload and semaphores asynchronously; outputs are 0 within the reset assertion.
// TESTING
//  1 Reset, then toggle s_tx_sema_q 0->1 with s_haddr_q=0x4000_0010, s_hwdata_q=0xCAFE_F00D (SYNC_STAGES=2):
//    m_rx_sema_q=1 on the 3rd edge; m_haddr_q=0x4000_0010 on the same edge once m_mask=0.
//  2 Hold m_mask=1 with a captured payload: m_haddr_q=0, m_hwdata_q=0, m_hsize_q=0;
//    m_hwrite_q and m_hselapb_q still show the captured values.
//  3 Change s_haddr_q without toggling: m_haddr_q holds its old value for 20 cycles.
//  4 Toggle again while m_rx_sema_q != m_tx_sema_q: m_proto_err=1 and stays 1 until HRESETMn low.
//  5 Back-to-back: tx_sema catches up on the edge the next toggle arrives: m_proto_err stays 0, second payload captured.
//  6 Assert HRESETMn mid-request with s_tx_sema_q=1:
//    all outputs 0 immediately; m_rx_sema_q=1 3 edges after release; s_hmastlock_q=1 reaches m_lock_q after 2 edges.

Source files
------------

// File: rtl/cmsdk_ahb_to_ahb_apb_async_master_rx_if.sv
// ----------------------------------------------------------------------------
// cmsdk_ahb_to_ahb_apb_async_master_rx_if
//
// Purpose: bundles the signals between the master-side receive stage of the
// async AHB-Lite to AHB-Lite/APB4 bridge and its neighbours. These are the
// slave-domain semaphore, lock and payload, the master FSM controls, and the
// captured, masked bus values.
//
// Signals:
//   s_tx_sema_q, s_hmastlock_q   slave semaphore toggle and lock flag (async)
//   s_h*_q                       slave request payload
//   m_mask, m_tx_sema_q          master FSM controls
//   m_rx_sema_q, m_lock_q        synchronised semaphore and lock
//   m_h*_q                       captured payload (some fields masked)
//   m_proto_err                  sticky protocol-error flag
//
// Modports:
//   slave   the receive stage itself
//   master  whoever drives the receive stage (the bridge, or a testbench)
// ----------------------------------------------------------------------------
interface cmsdk_ahb_to_ahb_apb_async_master_rx_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  s_tx_sema_q;
    logic                  s_hmastlock_q;
    logic [ADDR_WIDTH-1:0] s_haddr_q;
    logic                  s_hwrite_q;
    logic [2:0]            s_hsize_q;
    logic [3:0]            s_hprot_q;
    logic                  s_hselapb_q;
    logic                  s_hmastlock_pl_q;
    logic [31:0]           s_hwdata_q;
    logic                  m_mask;
    logic                  m_tx_sema_q;

    logic                  m_rx_sema_q;
    logic                  m_lock_q;
    logic [ADDR_WIDTH-1:0] m_haddr_q;
    logic [1:0]            m_haddr_q_1to0;
    logic [2:0]            m_hsize_q;
    logic [3:0]            m_hprot_q;
    logic                  m_hwrite_q;
    logic                  m_hselapb_q;
    logic                  m_hmastlock_q;
    logic [31:0]           m_hwdata_q;
    logic                  m_proto_err;

    modport slave (
        input  s_tx_sema_q, s_hmastlock_q, s_haddr_q, s_hwrite_q, s_hsize_q,
               s_hprot_q, s_hselapb_q, s_hmastlock_pl_q, s_hwdata_q,
               m_mask, m_tx_sema_q,
        output m_rx_sema_q, m_lock_q, m_haddr_q, m_haddr_q_1to0, m_hsize_q,
               m_hprot_q, m_hwrite_q, m_hselapb_q, m_hmastlock_q, m_hwdata_q,
               m_proto_err
    );

    modport master (
        output s_tx_sema_q, s_hmastlock_q, s_haddr_q, s_hwrite_q, s_hsize_q,
               s_hprot_q, s_hselapb_q, s_hmastlock_pl_q, s_hwdata_q,
               m_mask, m_tx_sema_q,
        input  m_rx_sema_q, m_lock_q, m_haddr_q, m_haddr_q_1to0, m_hsize_q,
               m_hprot_q, m_hwrite_q, m_hselapb_q, m_hmastlock_q, m_hwdata_q,
               m_proto_err
    );
endinterface

// File: rtl/cmsdk_ahb_to_ahb_apb_async_master_rx.sv
// ----------------------------------------------------------------------------
// cmsdk_ahb_to_ahb_apb_async_master_rx
//
// Purpose: master-side receive stage of the async AHB-Lite to AHB-Lite/APB4
// bridge, clocked by HCLKM. It synchronises the slave transmit semaphore and
// the slave lock flag into HCLKM. It captures the request payload on the
// edge where the synchronised semaphore first differs from m_rx_sema_q. It
// presents the captured payload, masked where required, to the master bus.
// It raises a sticky error if a new request lands while one is still
// outstanding.
//
// Ports:
//   HCLKM     master clock
//   HRESETMn  async active-low reset; clears every flop
//   bus       slave modport of cmsdk_ahb_to_ahb_apb_async_master_rx_if
//
// Parameters:
//   SYNC_STAGES  flops per synchroniser chain (2..4)
//   ADDR_WIDTH   address width (12..32); must match the interface
// ----------------------------------------------------------------------------
module cmsdk_ahb_to_ahb_apb_async_master_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic HCLKM,
    input  logic HRESETMn,
    cmsdk_ahb_to_ahb_apb_async_master_rx_if.slave bus
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] haddr;
        logic                  hwrite;
        logic [2:0]            hsize;
        logic [3:0]            hprot;
        logic                  hselapb;
        logic                  hmastlock;
        logic [31:0]           hwdata;
    } payload_t;

    logic [SYNC_STAGES-1:0] sema_sync_q, sema_sync_d;
    logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
    logic                   rx_sema_q,   rx_sema_d;
    logic                   proto_err_q, proto_err_d;
    payload_t               payload_q,   payload_d;

    logic sema_s;
    logic new_tog;
    logic busy;

    assign sema_s  = sema_sync_q[SYNC_STAGES-1];
    assign new_tog = sema_s != rx_sema_q;
    // m_tx_sema_q is sampled live. If the FSM retires the previous transfer
    // on the edge that exposes the new toggle, this is a legal back-to-back
    // case and not an error.
    assign busy    = rx_sema_q != bus.m_tx_sema_q;

    // NOTE: every variable gets a default at the top of always_comb, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        sema_sync_d = {sema_sync_q[SYNC_STAGES-2:0], bus.s_tx_sema_q};
        lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], bus.s_hmastlock_q};
        rx_sema_d   = rx_sema_q;
        payload_d   = payload_q;
        proto_err_d = proto_err_q | (new_tog & busy);

        // The payload has been stable since the slave toggled, and the toggle
        // has now cleared the synchroniser. Sampling it here is therefore
        // free of metastability, even though the payload is not synchronised.
        if (new_tog) begin
            rx_sema_d = sema_s;
            payload_d = '{
                haddr:     bus.s_haddr_q,
                hwrite:    bus.s_hwrite_q,
                hsize:     bus.s_hsize_q,
                hprot:     bus.s_hprot_q,
                hselapb:   bus.s_hselapb_q,
                hmastlock: bus.s_hmastlock_pl_q,
                hwdata:    bus.s_hwdata_q
            };
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of process ordering.
    // NOTE: the payload registers are reset as well. An interrupted request
    // then leaves no stale address or data on the bus after reset.
    always_ff @(posedge HCLKM or negedge HRESETMn) begin
        if (!HRESETMn) begin
            sema_sync_q <= '0;
            lock_sync_q <= '0;
            rx_sema_q   <= 1'b0;
            proto_err_q <= 1'b0;
            payload_q   <= '0;
        end else begin
            sema_sync_q <= sema_sync_d;
            lock_sync_q <= lock_sync_d;
            rx_sema_q   <= rx_sema_d;
            proto_err_q <= proto_err_d;
            payload_q   <= payload_d;
        end
    end

    assign bus.m_rx_sema_q    = rx_sema_q;
    assign bus.m_lock_q       = lock_sync_q[SYNC_STAGES-1];
    assign bus.m_proto_err    = proto_err_q;

    // Bus-facing fields are zeroed while no cycle is active. The FSM needs
    // the control fields below while idle, so they bypass the mask.
    assign bus.m_haddr_q      = payload_q.haddr  & {ADDR_WIDTH{~bus.m_mask}};
    assign bus.m_hsize_q      = payload_q.hsize  & {3{~bus.m_mask}};
    assign bus.m_hprot_q      = payload_q.hprot  & {4{~bus.m_mask}};
    assign bus.m_hwdata_q     = payload_q.hwdata & {32{~bus.m_mask}};
    assign bus.m_haddr_q_1to0 = payload_q.haddr[1:0];
    assign bus.m_hwrite_q     = payload_q.hwrite;
    assign bus.m_hselapb_q    = payload_q.hselapb;
    assign bus.m_hmastlock_q  = payload_q.hmastlock;

endmodule

// File: tb/tb_cmsdk_ahb_to_ahb_apb_async_master_rx.sv
// ----------------------------------------------------------------------------
// tb_cmsdk_ahb_to_ahb_apb_async_master_rx
//
// Directed bench for the master-side receive stage with SYNC_STAGES=2. The
// stimulus changes #1 after a rising edge. The outputs are sampled at that
// same point, which is well clear of the next edge.
// ----------------------------------------------------------------------------
module tb_cmsdk_ahb_to_ahb_apb_async_master_rx;

    localparam int AW = 32;

    logic HCLKM    = 1'b0;
    logic HRESETMn = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    cmsdk_ahb_to_ahb_apb_async_master_rx_if #(.ADDR_WIDTH(AW)) bus_if ();

    cmsdk_ahb_to_ahb_apb_async_master_rx #(
        .SYNC_STAGES(2),
        .ADDR_WIDTH (AW)
    ) dut (
        .HCLKM   (HCLKM),
        .HRESETMn(HRESETMn),
        .bus     (bus_if)
    );

    always #5 HCLKM = ~HCLKM;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge HCLKM);
        #1;
    endtask

    task automatic set_payload(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic wr, input logic [2:0] sz, input logic [3:0] prot,
                               input logic apb, input logic lk);
        bus_if.s_haddr_q        = addr;
        bus_if.s_hwdata_q       = wdata;
        bus_if.s_hwrite_q       = wr;
        bus_if.s_hsize_q        = sz;
        bus_if.s_hprot_q        = prot;
        bus_if.s_hselapb_q      = apb;
        bus_if.s_hmastlock_pl_q = lk;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".rx_sema"},   bus_if.m_rx_sema_q,    0);
        check({tag, ".lock"},      bus_if.m_lock_q,       0);
        check({tag, ".haddr"},     bus_if.m_haddr_q,      0);
        check({tag, ".haddr1to0"}, bus_if.m_haddr_q_1to0, 0);
        check({tag, ".hsize"},     bus_if.m_hsize_q,      0);
        check({tag, ".hprot"},     bus_if.m_hprot_q,      0);
        check({tag, ".hwrite"},    bus_if.m_hwrite_q,     0);
        check({tag, ".hselapb"},   bus_if.m_hselapb_q,    0);
        check({tag, ".hmastlock"}, bus_if.m_hmastlock_q,  0);
        check({tag, ".hwdata"},    bus_if.m_hwdata_q,     0);
        check({tag, ".proto_err"}, bus_if.m_proto_err,    0);
    endtask

    initial begin
        bus_if.s_tx_sema_q   = 1'b0;
        bus_if.s_hmastlock_q = 1'b0;
        bus_if.m_mask        = 1'b0;
        bus_if.m_tx_sema_q   = 1'b0;
        set_payload(32'h0, 32'h0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0);

        // Reset state. The mask is off, so the masked outputs are not hiding anything.
        #23;
        check_all_zero("reset");
        @(posedge HCLKM); #1;
        HRESETMn = 1'b1;

        // 1: first request; m_rx_sema_q rises on the 3rd edge after the toggle.
        set_payload(32'h4000_0010, 32'hCAFE_F00D, 1'b1, 3'd2, 4'hB, 1'b1, 1'b0);
        bus_if.s_tx_sema_q = 1'b1;
        tick(1); check("t1.edge1.rx_sema", bus_if.m_rx_sema_q, 0);
        tick(1); check("t1.edge2.rx_sema", bus_if.m_rx_sema_q, 0);
                 check("t1.edge2.haddr",   bus_if.m_haddr_q,   0);
        tick(1); check("t1.edge3.rx_sema", bus_if.m_rx_sema_q, 1);
                 check("t1.haddr",  bus_if.m_haddr_q,  32'h4000_0010);
                 check("t1.hwdata", bus_if.m_hwdata_q, 32'hCAFE_F00D);
                 check("t1.hsize",  bus_if.m_hsize_q,  3'd2);
                 check("t1.hprot",  bus_if.m_hprot_q,  4'hB);
                 check("t1.proto_err", bus_if.m_proto_err, 0);

        // 2: mask hides the bus fields, but the control fields still show.
        bus_if.m_mask = 1'b1;
        #1;
        check("t2.haddr",   bus_if.m_haddr_q,   0);
        check("t2.hwdata",  bus_if.m_hwdata_q,  0);
        check("t2.hsize",   bus_if.m_hsize_q,   0);
        check("t2.hprot",   bus_if.m_hprot_q,   0);
        check("t2.hwrite",  bus_if.m_hwrite_q,  1);
        check("t2.hselapb", bus_if.m_hselapb_q, 1);
        bus_if.m_mask = 1'b0;

        // 3: a payload change without a toggle is ignored. The transfer stays outstanding.
        bus_if.s_haddr_q = 32'h1234_5678;
        tick(20);
        check("t3.haddr",     bus_if.m_haddr_q,   32'h4000_0010);
        check("t3.rx_sema",   bus_if.m_rx_sema_q, 1);
        check("t3.proto_err", bus_if.m_proto_err, 0);

        // 5: back-to-back. The FSM retires on the edge that exposes the new toggle.
        set_payload(32'h5000_0020, 32'h1111_2222, 1'b0, 3'd1, 4'h3, 1'b0, 1'b0);
        bus_if.s_tx_sema_q = 1'b0;
        tick(2);
        check("t5.edge2.rx_sema", bus_if.m_rx_sema_q, 1);
        bus_if.m_tx_sema_q = 1'b1;
        tick(1);
        check("t5.rx_sema",   bus_if.m_rx_sema_q, 0);
        check("t5.haddr",     bus_if.m_haddr_q,   32'h5000_0020);
        check("t5.hwdata",    bus_if.m_hwdata_q,  32'h1111_2222);
        check("t5.hwrite",    bus_if.m_hwrite_q,  0);
        check("t5.proto_err", bus_if.m_proto_err, 0);

        // 4: toggle while still busy (rx=0, tx=1). The error is sticky and the last toggle wins.
        set_payload(32'h6000_0033, 32'hDEAD_BEEF, 1'b1, 3'd0, 4'h1, 1'b1, 1'b1);
        bus_if.s_tx_sema_q = 1'b1;
        tick(2);
        check("t4.edge2.proto_err", bus_if.m_proto_err, 0);
        tick(1);
        check("t4.proto_err", bus_if.m_proto_err, 1);
        check("t4.rx_sema",   bus_if.m_rx_sema_q, 1);
        check("t4.haddr",     bus_if.m_haddr_q,   32'h6000_0033);
        bus_if.m_mask = 1'b1;
        #1;
        check("t4.masked.haddr",   bus_if.m_haddr_q,      0);
        check("t4.haddr1to0",      bus_if.m_haddr_q_1to0, 2'd3);
        check("t4.hmastlock",      bus_if.m_hmastlock_q,  1);
        bus_if.m_mask = 1'b0;
        tick(10);
        check("t4.sticky.proto_err", bus_if.m_proto_err, 1);

        // 6: reset mid-request with the toggle and lock held high.
        bus_if.s_hmastlock_q = 1'b1;
        tick(3);
        check("t6.pre.lock", bus_if.m_lock_q, 1);
        HRESETMn = 1'b0;
        bus_if.m_tx_sema_q = 1'b0;
        #1;
        check_all_zero("t6.rst");
        tick(1);
        HRESETMn = 1'b1;
        tick(1);
        check("t6.edge1.rx_sema", bus_if.m_rx_sema_q, 0);
        check("t6.edge1.lock",    bus_if.m_lock_q,    0);
        tick(1);
        check("t6.edge2.rx_sema", bus_if.m_rx_sema_q, 0);
        check("t6.edge2.lock",    bus_if.m_lock_q,    1);
        tick(1);
        check("t6.edge3.rx_sema", bus_if.m_rx_sema_q, 1);
        check("t6.haddr",         bus_if.m_haddr_q,   32'h6000_0033);
        check("t6.proto_err",     bus_if.m_proto_err, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
